// File: rtl/xgmii_link_fault_monitor.sv
// Receive-side link fault monitor for a 32-bit XGMII lane group.
// Qualifies local/remote fault ordered sets with count/window hysteresis.
`timescale 1ns/1ps
module xgmii_link_fault_monitor #(
  parameter int SEQ_THRESHOLD = 4,
  parameter int COL_WINDOW    = 128
) (
  input  logic        xgmii_rx_clk,
  input  logic        rst_n,
  input  logic [3:0]  xgmii_rxc,
  input  logic [31:0] xgmii_rxd,
  output logic [1:0]  link_fault,
  output logic        local_fault,
  output logic        remote_fault,
  output logic        fault_changed,
  output logic [15:0] fault_count
);

  localparam int COL_W = $clog2(COL_WINDOW) + 1;
  localparam logic [3:0]       SEQ_THR = 4'(SEQ_THRESHOLD);
  localparam logic [COL_W-1:0] COL_WIN = COL_W'(COL_WINDOW);
  localparam logic [COL_W-1:0] COL_ZERO = '0;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Returns {is_fault, fault_type}; type 01 = local, 10 = remote.
  function automatic logic [2:0] decode_column(input logic [3:0] rxc, input logic [31:0] rxd);
    logic frame_ok;
    frame_ok = (rxc == 4'b0001) && (rxd[7:0] == 8'h9C) && (rxd[23:8] == 16'h0000);
    if (frame_ok && (rxd[31:24] == 8'h01)) begin
      return {1'b1, 2'b01};
    end else if (frame_ok && (rxd[31:24] == 8'h02)) begin
      return {1'b1, 2'b10};
    end else begin
      return 3'b000;
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [1:0]       last_type_r, last_type_nxt_s;
  logic [3:0]       seq_cnt_r, seq_cnt_nxt_s, seq_inc_s;
  logic [COL_W-1:0] col_cnt_r, col_cnt_nxt_s, col_inc_s;
  logic [1:0]       link_fault_r, link_fault_nxt_s;
  logic             fault_changed_r;
  logic [15:0]      fault_count_r;
  logic             local_fault_r, remote_fault_r;
  logic [2:0]       col_dec_s;
  logic             is_fault_s;
  logic [1:0]       col_type_s;
  logic             count_inc_s;

  // Column classification and saturating increments.
  always_comb begin
    col_dec_s  = decode_column(xgmii_rxc, xgmii_rxd);
    is_fault_s = col_dec_s[2];
    col_type_s = col_dec_s[1:0];
    if (seq_cnt_r == 4'hF) begin
      seq_inc_s = seq_cnt_r;
    end else begin
      seq_inc_s = seq_cnt_r + 4'd1;
    end
    if (col_cnt_r == COL_WIN) begin
      col_inc_s = col_cnt_r;
    end else begin
      col_inc_s = col_cnt_r + COL_W'(1);
    end
  end

  // Qualification state machine: next state, counters and fault status.
  always_comb begin
    state_nxt_s      = state_r;
    last_type_nxt_s  = last_type_r;
    seq_cnt_nxt_s    = seq_cnt_r;
    col_cnt_nxt_s    = col_cnt_r;
    link_fault_nxt_s = link_fault_r;
    case (state_r)
      ST_INIT: begin
        if (is_fault_s) begin
          last_type_nxt_s = col_type_s;
          seq_cnt_nxt_s   = 4'd1;
          col_cnt_nxt_s   = COL_ZERO;
          state_nxt_s     = ST_COUNT;
        end else begin
          state_nxt_s     = ST_INIT;
        end
      end
      ST_COUNT: begin
        if (is_fault_s && (col_type_s == last_type_r)) begin
          seq_cnt_nxt_s = seq_inc_s;
          col_cnt_nxt_s = COL_ZERO;
          if (seq_inc_s == SEQ_THR) begin
            state_nxt_s      = ST_FAULT;
            link_fault_nxt_s = last_type_r;
          end else begin
            state_nxt_s      = ST_COUNT;
          end
        end else if (is_fault_s) begin
          last_type_nxt_s = col_type_s;
          seq_cnt_nxt_s   = 4'd1;
          col_cnt_nxt_s   = COL_ZERO;
        end else begin
          col_cnt_nxt_s = col_inc_s;
          if (col_inc_s == COL_WIN) begin
            state_nxt_s      = ST_INIT;
            link_fault_nxt_s = 2'b00;
            seq_cnt_nxt_s    = 4'd0;
            col_cnt_nxt_s    = COL_ZERO;
          end else begin
            state_nxt_s      = ST_COUNT;
          end
        end
      end
      ST_FAULT: begin
        if (is_fault_s && (col_type_s == last_type_r)) begin
          col_cnt_nxt_s = COL_ZERO;
        end else if (is_fault_s) begin
          // Old status holds until the new type qualifies on its own.
          last_type_nxt_s = col_type_s;
          seq_cnt_nxt_s   = 4'd1;
          col_cnt_nxt_s   = COL_ZERO;
          state_nxt_s     = ST_COUNT;
        end else begin
          col_cnt_nxt_s = col_inc_s;
          if (col_inc_s == COL_WIN) begin
            state_nxt_s      = ST_INIT;
            link_fault_nxt_s = 2'b00;
            seq_cnt_nxt_s    = 4'd0;
            col_cnt_nxt_s    = COL_ZERO;
          end else begin
            state_nxt_s      = ST_FAULT;
          end
        end
      end
      default: begin
        state_nxt_s      = ST_INIT;
        last_type_nxt_s  = 2'b00;
        seq_cnt_nxt_s    = 4'd0;
        col_cnt_nxt_s    = COL_ZERO;
        link_fault_nxt_s = 2'b00;
      end
    endcase
  end

  // Only OK -> fault transitions are counted; local <-> remote is not.
  always_comb begin
    if ((link_fault_r == 2'b00) && (link_fault_nxt_s != 2'b00) && (fault_count_r != 16'hFFFF)) begin
      count_inc_s = 1'b1;
    end else begin
      count_inc_s = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge xgmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      last_type_r <= 2'b00;
      seq_cnt_r   <= 4'd0;
      col_cnt_r   <= COL_ZERO;
    end else begin
      state_r     <= state_nxt_s;
      last_type_r <= last_type_nxt_s;
      seq_cnt_r   <= seq_cnt_nxt_s;
      col_cnt_r   <= col_cnt_nxt_s;
    end
  end

  // Registered status outputs.
  always_ff @(posedge xgmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      link_fault_r    <= 2'b00;
      local_fault_r   <= 1'b0;
      remote_fault_r  <= 1'b0;
      fault_changed_r <= 1'b0;
      fault_count_r   <= 16'd0;
    end else begin
      link_fault_r    <= link_fault_nxt_s;
      local_fault_r   <= (link_fault_nxt_s == 2'b01);
      remote_fault_r  <= (link_fault_nxt_s == 2'b10);
      fault_changed_r <= (link_fault_nxt_s != link_fault_r);
      if (count_inc_s) begin
        fault_count_r <= fault_count_r + 16'd1;
      end else begin
        fault_count_r <= fault_count_r;
      end
    end
  end

  assign link_fault    = link_fault_r;
  assign local_fault   = local_fault_r;
  assign remote_fault  = remote_fault_r;
  assign fault_changed = fault_changed_r;
  assign fault_count   = fault_count_r;

endmodule

// File: tb/tb_xgmii_link_fault_monitor.sv
// Scoreboard bench for xgmii_link_fault_monitor: every driven column queues
// its expected registered outputs, checked one cycle later.
`timescale 1ns/1ps
module tb_xgmii_link_fault_monitor;

  localparam logic [7:0]  LOC  = 8'h01;
  localparam logic [7:0]  REM  = 8'h02;
  localparam logic [3:0]  IDLE_C = 4'hF;
  localparam logic [31:0] IDLE_D = 32'h07070707;

  typedef struct packed {
    logic [1:0]  lf;
    logic        chg;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  rxc = IDLE_C;
  logic [31:0] rxd = IDLE_D;
  logic [1:0]  link_fault;
  logic        local_fault, remote_fault, fault_changed;
  logic [15:0] fault_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   col_no = 0;
  exp_t exp_q[$];
  exp_t e;

  xgmii_link_fault_monitor dut (
    .xgmii_rx_clk (clk),
    .rst_n        (rst_n),
    .xgmii_rxc    (rxc),
    .xgmii_rxd    (rxd),
    .link_fault   (link_fault),
    .local_fault  (local_fault),
    .remote_fault (remote_fault),
    .fault_changed(fault_changed),
    .fault_count  (fault_count)
  );

  always #4 clk = ~clk;

  // Scoreboard: compare the column sampled at this edge against its queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      col_no++;
      vectors++;
      if ({link_fault, local_fault, remote_fault, fault_changed, fault_count} !==
          {e.lf, (e.lf == 2'b01), (e.lf == 2'b10), e.chg, e.cnt}) begin
        miscompares++;
        $display("FAIL column %0d: got lf=%b loc=%b rem=%b chg=%b cnt=%0d, expected lf=%b chg=%b cnt=%0d",
                 col_no, link_fault, local_fault, remote_fault, fault_changed, fault_count,
                 e.lf, e.chg, e.cnt);
      end
    end
  end

  task automatic apply(input logic [3:0] c, input logic [31:0] d,
                       input logic [1:0] x_lf, input logic x_chg, input logic [15:0] x_cnt);
    @(negedge clk);
    rxc = c;
    rxd = d;
    exp_q.push_back(exp_t'{lf: x_lf, chg: x_chg, cnt: x_cnt});
  endtask

  task automatic idles(input int n, input logic [1:0] x_lf, input logic [15:0] x_cnt);
    for (int i = 0; i < n; i++) apply(IDLE_C, IDLE_D, x_lf, 1'b0, x_cnt);
  endtask

  task automatic fcol(input logic [7:0] code, input logic [1:0] x_lf,
                      input logic x_chg, input logic [15:0] x_cnt);
    apply(4'b0001, {code, 8'h00, 8'h00, 8'h9C}, x_lf, x_chg, x_cnt);
  endtask

  task automatic flush();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({link_fault, local_fault, remote_fault, fault_changed, fault_count} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_state: got lf=%b chg=%b cnt=%0d, expected all zero",
               link_fault, fault_changed, fault_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idles(3, 2'b00, 16'd0);
    flush();
  endtask

  task automatic test_local_qualifies();
    for (int k = 1; k <= 4; k++) begin
      fcol(LOC, (k == 4) ? 2'b01 : 2'b00, (k == 4), (k == 4) ? 16'd1 : 16'd0);
      if (k < 4) idles(10, 2'b00, 16'd0);
    end
    flush();
    vectors++;
    if (fault_count !== 16'd1 || local_fault !== 1'b1) begin
      miscompares++;
      $display("FAIL local_qualifies: got cnt=%0d loc=%b, expected cnt=1 loc=1", fault_count, local_fault);
    end
    idles(127, 2'b01, 16'd1);
    apply(IDLE_C, IDLE_D, 2'b00, 1'b1, 16'd1);
    flush();
  endtask

  task automatic test_window_expires();
    repeat (3) fcol(LOC, 2'b00, 1'b0, 16'd1);
    idles(128, 2'b00, 16'd1);
    repeat (3) fcol(LOC, 2'b00, 1'b0, 16'd1);
    idles(128, 2'b00, 16'd1);
    flush();
    vectors++;
    if (link_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL window_expires: got lf=%b, expected 00", link_fault);
    end
  endtask

  task automatic test_clear_boundary();
    repeat (3) fcol(LOC, 2'b00, 1'b0, 16'd1);
    fcol(LOC, 2'b01, 1'b1, 16'd2);
    idles(127, 2'b01, 16'd2);
    fcol(LOC, 2'b01, 1'b0, 16'd2);
    idles(127, 2'b01, 16'd2);
    apply(IDLE_C, IDLE_D, 2'b00, 1'b1, 16'd2);
    flush();
    @(posedge clk);
    #2;
    vectors++;
    if (fault_changed !== 1'b0 || link_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_strobe_width: got chg=%b lf=%b, expected chg=0 lf=00", fault_changed, link_fault);
    end
  endtask

  task automatic test_type_switch();
    repeat (3) fcol(LOC, 2'b00, 1'b0, 16'd2);
    fcol(LOC, 2'b01, 1'b1, 16'd3);
    repeat (3) fcol(REM, 2'b01, 1'b0, 16'd3);
    fcol(REM, 2'b10, 1'b1, 16'd3);
    // A lone local column moves back to counting; the remote status must still age out.
    fcol(LOC, 2'b10, 1'b0, 16'd3);
    idles(127, 2'b10, 16'd3);
    apply(IDLE_C, IDLE_D, 2'b00, 1'b1, 16'd3);
    flush();
    vectors++;
    if (fault_count !== 16'd3) begin
      miscompares++;
      $display("FAIL type_switch_count: got cnt=%0d, expected 3", fault_count);
    end
  endtask

  task automatic test_malformed();
    repeat (8) apply(4'b0001, {8'h03, 8'h00, 8'h00, 8'h9C}, 2'b00, 1'b0, 16'd3);
    repeat (8) apply(4'b0001, {8'h01, 8'h00, 8'h01, 8'h9C}, 2'b00, 1'b0, 16'd3);
    repeat (8) apply(4'b0011, {8'h01, 8'h00, 8'h00, 8'h9C}, 2'b00, 1'b0, 16'd3);
    repeat (8) apply(4'b0001, {8'h02, 8'h05, 8'h00, 8'h9C}, 2'b00, 1'b0, 16'd3);
    repeat (3) fcol(LOC, 2'b00, 1'b0, 16'd3);
    idles(128, 2'b00, 16'd3);
    flush();
    vectors++;
    if (link_fault !== 2'b00) begin
      miscompares++;
      $display("FAIL malformed: got lf=%b, expected 00", link_fault);
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) fcol(REM, 2'b00, 1'b0, 16'd3);
    fcol(REM, 2'b10, 1'b1, 16'd4);
    flush();
    rxc = IDLE_C;
    rxd = IDLE_D;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({link_fault, local_fault, remote_fault, fault_changed, fault_count} !== 21'd0) begin
      miscompares++;
      $display("FAIL async_reset: got lf=%b rem=%b chg=%b cnt=%0d, expected all zero",
               link_fault, remote_fault, fault_changed, fault_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) fcol(REM, 2'b00, 1'b0, 16'd0);
    fcol(REM, 2'b10, 1'b1, 16'd1);
    flush();
  endtask

  task automatic test_back_to_back();
    repeat (3) fcol(LOC, 2'b10, 1'b0, 16'd1);
    fcol(LOC, 2'b01, 1'b1, 16'd1);
    repeat (3) fcol(REM, 2'b01, 1'b0, 16'd1);
    repeat (4) fcol(LOC, 2'b01, 1'b0, 16'd1);
    idles(127, 2'b01, 16'd1);
    apply(IDLE_C, IDLE_D, 2'b00, 1'b1, 16'd1);
    flush();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_local_qualifies();
    test_window_expires();
    test_clear_boundary();
    test_type_switch();
    test_malformed();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
